// File: rtl/display_share_ctrl_if.sv
// Display-share bus: source requests and values in, segment drive and status out.
interface display_share_ctrl_if #(
  parameter int N_SRC = 2
);
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]    src_en;
  logic [11*N_SRC-1:0] src_val;
  logic [6:0]          seg2;
  logic [6:0]          seg1;
  logic [6:0]          seg0;
  logic [SW-1:0]       cur_src;
  logic                upd;

  modport master (
    output src_en, src_val,
    input  seg2, seg1, seg0, cur_src, upd
  );

  modport slave (
    input  src_en, src_val,
    output seg2, seg1, seg0, cur_src, upd
  );
endinterface

// File: rtl/display_share_ctrl.sv
// Time-shares a 3-digit active-low 7-seg display among N_SRC 11-bit sources.
// Round-robin source selection with a dwell time, sequential double-dabble
// conversion (one bit per cycle), leading-zero blanking and overflow dashes.
module display_share_ctrl #(
  parameter int N_SRC = 2,
  parameter int DWELL = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_share_ctrl_if.slave  bus
);
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int DW = $clog2(DWELL + 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEL   = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [6:0]    BLANK     = 7'b1111111;
  localparam logic [6:0]    DASH      = 7'b0111111;
  localparam logic [DW-1:0] DWELL_MAX = '1;
  localparam logic [DW-1:0] DWELL_THR = DW'(DWELL);

  logic [1:0]    state;
  logic [10:0]   val;
  logic [10:0]   sh;
  logic [11:0]   bcd;
  logic [11:0]   bcd_adj;
  logic [3:0]    bitcnt;
  logic [DW-1:0] dwell;
  logic          adv;
  logic [6:0]    seg2_q;
  logic [6:0]    seg1_q;
  logic [6:0]    seg0_q;
  logic [SW-1:0] cur_src_q;
  logic          upd_q;

  int unsigned   cur_i;
  int unsigned   nxt_i;
  int unsigned   tgt_i;
  int unsigned   idx;
  logic          found;
  logic          en_cur;
  logic [N_SRC-1:0] en_sh;
  logic [N_SRC-1:0] en_cur_sh;
  logic [10:0]   tgt_val;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = BLANK;
    endcase
    return s;
  endfunction

  // Round-robin target: next enabled index after cur_src (wrapping), shifts
  // avoid variable-width bit selects on the request vector.
  always_comb begin
    cur_i     = 32'(cur_src_q);
    nxt_i     = cur_i;
    found     = 1'b0;
    idx       = 0;
    en_sh     = '0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      idx = cur_i + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      en_sh = bus.src_en >> idx;
      if (!found && en_sh[0]) begin
        nxt_i = idx;
        found = 1'b1;
      end
    end
    tgt_i     = adv ? nxt_i : cur_i;
    tgt_val   = 11'(bus.src_val >> (11 * tgt_i));
    en_cur_sh = bus.src_en >> cur_src_q;
    en_cur    = en_cur_sh[0];
  end

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  always_comb begin
    bcd_adj = bcd;
    if (bcd[3:0]  >= 4'd5) bcd_adj[3:0]  = bcd[3:0]  + 4'd3;
    if (bcd[7:4]  >= 4'd5) bcd_adj[7:4]  = bcd[7:4]  + 4'd3;
    if (bcd[11:8] >= 4'd5) bcd_adj[11:8] = bcd[11:8] + 4'd3;
  end

  // Controller FSM, converter datapath, dwell counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      val       <= '0;
      sh        <= '0;
      bcd       <= '0;
      bitcnt    <= '0;
      dwell     <= '0;
      adv       <= 1'b0;
      seg2_q    <= BLANK;
      seg1_q    <= BLANK;
      seg0_q    <= BLANK;
      cur_src_q <= '0;
      upd_q     <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (state != IDLE && dwell != DWELL_MAX) dwell <= dwell + 1'b1;
      case (state)
        IDLE: begin
          seg2_q <= BLANK;
          seg1_q <= BLANK;
          seg0_q <= BLANK;
          if (bus.src_en != '0) state <= SEL;
        end
        SEL: begin
          if (bus.src_en == '0) begin
            state  <= IDLE;
            seg2_q <= BLANK;
            seg1_q <= BLANK;
            seg0_q <= BLANK;
          end else begin
            val    <= tgt_val;
            sh     <= tgt_val;
            bcd    <= '0;
            bitcnt <= '0;
            state  <= SHIFT;
            if (tgt_i != cur_i) begin
              cur_src_q <= SW'(tgt_i);
              dwell     <= '0;
            end
          end
        end
        SHIFT: begin
          bcd    <= {bcd_adj[10:0], sh[10]};
          sh     <= {sh[9:0], 1'b0};
          bitcnt <= bitcnt + 4'd1;
          if (bitcnt == 4'd10) state <= WRITE;
        end
        default: begin
          upd_q <= 1'b1;
          if (val > 11'd999) begin
            seg2_q <= DASH;
            seg1_q <= DASH;
            seg0_q <= DASH;
          end else begin
            seg0_q <= seg_enc(bcd[3:0]);
            seg1_q <= (val >= 11'd10)  ? seg_enc(bcd[7:4])  : BLANK;
            seg2_q <= (val >= 11'd100) ? seg_enc(bcd[11:8]) : BLANK;
          end
          adv   <= (dwell >= DWELL_THR) || !en_cur;
          state <= SEL;
        end
      endcase
    end
  end

  assign bus.seg2    = seg2_q;
  assign bus.seg1    = seg1_q;
  assign bus.seg0    = seg0_q;
  assign bus.cur_src = cur_src_q;
  assign bus.upd     = upd_q;
endmodule
